uart_rx_deframer: RTL and testbench



---
 rtl/uart_rx_deframer.sv | 114 +++++++++++
 tb/tb_uart_rx_deframer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: 8N1 UART receiver that packs WIDTH/8 bytes, first byte least significant, into one word.
module uart_rx_deframer #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rxd,
    output logic [WIDTH-1:0] p,
    output logic             valid,
    output logic             frame_err
);
    localparam int NB = WIDTH / 8;
    localparam int H  = CLKS_PER_BIT / 2;
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = NB > 1 ? $clog2(NB) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t           state, state_n;
    logic [1:0]       sync;
    logic             rxd_s;
    logic [TW-1:0]    timer, timer_n;
    logic [2:0]       bit_cnt, bit_n;
    logic [7:0]       shift, shift_n;
    logic [WIDTH-1:0] stage, stage_n, p_n;
    logic [BW-1:0]    bcnt, bcnt_n;
    logic             valid_n, ferr_n, tick, half;

    assign rxd_s = sync[1];
    assign tick  = timer == TW'(CLKS_PER_BIT - 1);
    assign half  = timer == TW'(H - 1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync      <= 2'b11;
            state     <= IDLE;
            timer     <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            stage     <= '0;
            bcnt      <= '0;
            p         <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sync      <= {sync[0], rxd};
            state     <= state_n;
            timer     <= timer_n;
            bit_cnt   <= bit_n;
            shift     <= shift_n;
            stage     <= stage_n;
            bcnt      <= bcnt_n;
            p         <= p_n;
            valid     <= valid_n;
            frame_err <= ferr_n;
        end
    end

    always_comb begin
        state_n = state;
        timer_n = timer + 1'b1;
        bit_n   = bit_cnt;
        shift_n = shift;
        stage_n = stage;
        bcnt_n  = bcnt;
        p_n     = p;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
        case (state)
            IDLE: begin
                timer_n = '0;
                if (!rxd_s) state_n = START;
            end
            START: if (half) begin
                timer_n = '0;
                bit_n   = '0;
                state_n = rxd_s ? IDLE : DATA;
            end
            DATA: if (tick) begin
                timer_n = '0;
                shift_n = {rxd_s, shift[7:1]};
                bit_n   = bit_cnt + 1'b1;
                if (bit_cnt == 3'd7) state_n = STOP;
            end
            STOP: if (tick) begin
                timer_n = '0;
                if (rxd_s) begin
                    state_n = IDLE;
                    for (int k = 0; k < NB; k++)
                        if (bcnt == BW'(k)) stage_n[8*k +: 8] = shift;
                    // Last byte of the word publishes the freshly completed staging word
                    if (bcnt == BW'(NB - 1)) begin
                        p_n     = stage_n;
                        valid_n = 1'b1;
                        bcnt_n  = '0;
                    end else begin
                        bcnt_n = bcnt + 1'b1;
                    end
                end else begin
                    state_n = BREAK;
                    stage_n = '0;
                    bcnt_n  = '0;
                    ferr_n  = 1'b1;
                end
            end
            BREAK: begin
                timer_n = '0;
                if (rxd_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb_uart_rx_deframer: scoreboard bench over three receiver configurations sharing one clock.
module tb_uart_rx_deframer;
    typedef struct {
        logic [63:0] w;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rxd16 = 1'b1, rxd8 = 1'b1, rxd32 = 1'b1;
    logic [15:0] p16;
    logic [7:0]  p8;
    logic [31:0] p32;
    logic        v16, v8, v32, fe16, fe8, fe32;
    int          cyc = 0;
    int          tests = 0, fails = 0;
    int          nv16 = 0, nv8 = 0, nv32 = 0, nfe16 = 0, nfe8 = 0, nfe32 = 0;
    exp_t        q16[$], q8[$], q32[$];
    exp_t        e16, e8, e32;

    uart_rx_deframer #(.WIDTH(16), .CLKS_PER_BIT(16)) d16 (
        .clk(clk), .rst_n(rst_n), .rxd(rxd16), .p(p16), .valid(v16), .frame_err(fe16));
    uart_rx_deframer #(.WIDTH(8), .CLKS_PER_BIT(16)) d8 (
        .clk(clk), .rst_n(rst_n), .rxd(rxd8), .p(p8), .valid(v8), .frame_err(fe8));
    uart_rx_deframer #(.WIDTH(32), .CLKS_PER_BIT(4)) d32 (
        .clk(clk), .rst_n(rst_n), .rxd(rxd32), .p(p32), .valid(v32), .frame_err(fe32));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    always @(negedge clk) if (rst_n) begin
        if (v16 || fe16) begin
            tests++;
            if (v16 && fe16) begin fails++; $display("FAIL strobes16: valid and frame_err both high at cycle %0d", cyc); end
        end
        if (fe16) nfe16++;
        if (v16) begin
            nv16++;
            tests++;
            if (q16.size() == 0) begin
                fails++;
                $display("FAIL valid16: unexpected valid p=%h at cycle %0d", p16, cyc);
            end else begin
                e16 = q16.pop_front();
                if (p16 !== e16.w[15:0]) begin fails++; $display("FAIL word16: got %h expected %h", p16, e16.w[15:0]); end
                if (e16.cyc >= 0) begin
                    tests++;
                    if (cyc !== e16.cyc) begin fails++; $display("FAIL latency16: valid at cycle %0d expected %0d", cyc, e16.cyc); end
                end
            end
        end
    end

    always @(negedge clk) if (rst_n) begin
        if (v8 || fe8) begin
            tests++;
            if (v8 && fe8) begin fails++; $display("FAIL strobes8: valid and frame_err both high at cycle %0d", cyc); end
        end
        if (fe8) nfe8++;
        if (v8) begin
            nv8++;
            tests++;
            if (q8.size() == 0) begin
                fails++;
                $display("FAIL valid8: unexpected valid p=%h at cycle %0d", p8, cyc);
            end else begin
                e8 = q8.pop_front();
                if (p8 !== e8.w[7:0]) begin fails++; $display("FAIL word8: got %h expected %h", p8, e8.w[7:0]); end
            end
        end
    end

    always @(negedge clk) if (rst_n) begin
        if (v32 || fe32) begin
            tests++;
            if (v32 && fe32) begin fails++; $display("FAIL strobes32: valid and frame_err both high at cycle %0d", cyc); end
        end
        if (fe32) nfe32++;
        if (v32) begin
            nv32++;
            tests++;
            if (q32.size() == 0) begin
                fails++;
                $display("FAIL valid32: unexpected valid p=%h at cycle %0d", p32, cyc);
            end else begin
                e32 = q32.pop_front();
                if (p32 !== e32.w[31:0]) begin fails++; $display("FAIL word32: got %h expected %h", p32, e32.w[31:0]); end
            end
        end
    end

    task automatic set_rx(input int d, input logic v);
        if (d == 16) rxd16 = v;
        else if (d == 8) rxd8 = v;
        else rxd32 = v;
    endtask

    task automatic push(input int d, input exp_t e);
        if (d == 16) q16.push_back(e);
        else if (d == 8) q8.push_back(e);
        else q32.push_back(e);
    endtask

    // bad_stop > 0 holds the stop bit low for that many bit-times
    task automatic send_byte(input int d, input logic [7:0] b, input int cpb, input int bad_stop,
                             input bit last, input logic [63:0] w, input int lat);
        exp_t e;
        @(negedge clk);
        if (last) begin
            e.w   = w;
            e.cyc = lat >= 0 ? cyc + lat : -1;
            push(d, e);
        end
        set_rx(d, 1'b0);
        repeat (cpb - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            set_rx(d, b[i]);
            repeat (cpb - 1) @(negedge clk);
        end
        @(negedge clk);
        set_rx(d, bad_stop == 0);
        repeat (cpb * (bad_stop > 0 ? bad_stop : 1) - 1) @(negedge clk);
        if (bad_stop > 0) begin
            @(negedge clk);
            set_rx(d, 1'b1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        tests += 9;
        if (p16 !== 16'h0) begin fails++; $display("FAIL reset_p16: got %h expected 0", p16); end
        if (p8 !== 8'h0) begin fails++; $display("FAIL reset_p8: got %h expected 0", p8); end
        if (p32 !== 32'h0) begin fails++; $display("FAIL reset_p32: got %h expected 0", p32); end
        if (v16 !== 1'b0) begin fails++; $display("FAIL reset_v16: got %b expected 0", v16); end
        if (v8 !== 1'b0) begin fails++; $display("FAIL reset_v8: got %b expected 0", v8); end
        if (v32 !== 1'b0) begin fails++; $display("FAIL reset_v32: got %b expected 0", v32); end
        if (fe16 !== 1'b0) begin fails++; $display("FAIL reset_fe16: got %b expected 0", fe16); end
        if (fe8 !== 1'b0) begin fails++; $display("FAIL reset_fe8: got %b expected 0", fe8); end
        if (fe32 !== 1'b0) begin fails++; $display("FAIL reset_fe32: got %b expected 0", fe32); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int v0 = nv16, f0 = nfe16;
        send_byte(16, 8'hA5, 16, 0, 1'b0, 64'h0, -1);
        send_byte(16, 8'h3C, 16, 0, 1'b1, 64'h3CA5, 2 + 8 + 9 * 16 + 1);
        repeat (40) @(negedge clk);
        tests += 3;
        if (q16.size() != 0) begin fails++; $display("FAIL b2b_pending: %0d words never delivered, expected 0", q16.size()); q16.delete(); end
        if (nv16 - v0 != 1) begin fails++; $display("FAIL b2b_valid_count: got %0d expected 1", nv16 - v0); end
        if (nfe16 - f0 != 0) begin fails++; $display("FAIL b2b_ferr_count: got %0d expected 0", nfe16 - f0); end
    endtask

    task automatic test_glitch();
        int v0 = nv8, f0 = nfe8;
        @(negedge clk);
        rxd8 = 1'b0;
        repeat (4) @(negedge clk);
        rxd8 = 1'b1;
        repeat (40) @(negedge clk);
        tests += 2;
        if (nv8 - v0 != 0) begin fails++; $display("FAIL glitch_valid: got %0d expected 0", nv8 - v0); end
        if (nfe8 - f0 != 0) begin fails++; $display("FAIL glitch_ferr: got %0d expected 0", nfe8 - f0); end
        send_byte(8, 8'h5A, 16, 0, 1'b1, 64'h5A, -1);
        repeat (30) @(negedge clk);
        tests += 2;
        if (q8.size() != 0) begin fails++; $display("FAIL glitch_pending: %0d words never delivered, expected 0", q8.size()); q8.delete(); end
        if (p8 !== 8'h5A) begin fails++; $display("FAIL glitch_word: got %h expected 5a", p8); end
    endtask

    task automatic test_frame_error();
        int v0 = nv16, f0 = nfe16;
        send_byte(16, 8'h11, 16, 0, 1'b0, 64'h0, -1);
        send_byte(16, 8'h22, 16, 3, 1'b0, 64'h0, -1);
        repeat (40) @(negedge clk);
        tests += 3;
        if (nfe16 - f0 != 1) begin fails++; $display("FAIL ferr_count: got %0d expected 1", nfe16 - f0); end
        if (nv16 - v0 != 0) begin fails++; $display("FAIL ferr_valid: got %0d expected 0", nv16 - v0); end
        if (p16 !== 16'h3CA5) begin fails++; $display("FAIL ferr_p_held: got %h expected 3ca5", p16); end
        send_byte(16, 8'h33, 16, 0, 1'b0, 64'h0, -1);
        send_byte(16, 8'h44, 16, 0, 1'b1, 64'h4433, -1);
        repeat (30) @(negedge clk);
        tests += 3;
        if (q16.size() != 0) begin fails++; $display("FAIL ferr_pending: %0d words never delivered, expected 0", q16.size()); q16.delete(); end
        if (nv16 - v0 != 1) begin fails++; $display("FAIL ferr_recover_valid: got %0d expected 1", nv16 - v0); end
        if (nfe16 - f0 != 1) begin fails++; $display("FAIL ferr_recover_ferr: got %0d expected 1", nfe16 - f0); end
    endtask

    task automatic test_mid_frame_reset();
        int v0 = nv8, f0 = nfe8;
        fork
            send_byte(8, 8'hFF, 16, 0, 1'b0, 64'h0, -1);
            begin
                repeat (5 * 16 + 9) @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        join
        repeat (40) @(negedge clk);
        tests += 3;
        if (p8 !== 8'h00) begin fails++; $display("FAIL rst_p: got %h expected 0", p8); end
        if (nv8 - v0 != 0) begin fails++; $display("FAIL rst_valid: got %0d expected 0", nv8 - v0); end
        if (nfe8 - f0 != 0) begin fails++; $display("FAIL rst_ferr: got %0d expected 0", nfe8 - f0); end
        send_byte(8, 8'h81, 16, 0, 1'b1, 64'h81, -1);
        repeat (30) @(negedge clk);
        tests += 2;
        if (q8.size() != 0) begin fails++; $display("FAIL rst_pending: %0d words never delivered, expected 0", q8.size()); q8.delete(); end
        if (p8 !== 8'h81) begin fails++; $display("FAIL rst_word: got %h expected 81", p8); end
    endtask

    task automatic test_stream32();
        int v0 = nv32, f0 = nfe32;
        logic [63:0] w;
        for (int i = 0; i < 8; i++) begin
            w = (i < 4) ? 64'h04030201 : 64'h08070605;
            send_byte(32, 8'(i + 1), 4, 0, (i % 4) == 3, w, -1);
        end
        repeat (20) @(negedge clk);
        tests += 3;
        if (q32.size() != 0) begin fails++; $display("FAIL s32_pending: %0d words never delivered, expected 0", q32.size()); q32.delete(); end
        if (nv32 - v0 != 2) begin fails++; $display("FAIL s32_valid_count: got %0d expected 2", nv32 - v0); end
        if (nfe32 - f0 != 0) begin fails++; $display("FAIL s32_ferr: got %0d expected 0", nfe32 - f0); end
    endtask

    task automatic test_rate_error();
        int v0 = nv8, f0 = nfe8;
        send_byte(8, 8'hC3, 15, 0, 1'b1, 64'hC3, -1);
        repeat (40) @(negedge clk);
        tests += 4;
        if (q8.size() != 0) begin fails++; $display("FAIL rate_pending: %0d words never delivered, expected 0", q8.size()); q8.delete(); end
        if (p8 !== 8'hC3) begin fails++; $display("FAIL rate_word: got %h expected c3", p8); end
        if (nv8 - v0 != 1) begin fails++; $display("FAIL rate_valid: got %0d expected 1", nv8 - v0); end
        if (nfe8 - f0 != 0) begin fails++; $display("FAIL rate_ferr: got %0d expected 0", nfe8 - f0); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_mid_frame_reset();
        test_stream32();
        test_rate_error();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
